// File: rtl/dma_copy_engine.sv
// Memory-to-memory byte copy engine: bus master on a single-port memory with registered
// read data. Three cycles per byte (read strobe, read latency, write strobe).
module dma_copy_engine #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst_out,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  bytes_done,
    output logic              mem_ce,
    output logic              mem_nw_r,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, LAT, WR, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  bytes_q, bytes_d;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              busy_q, done_q, aborted_q, ce_q, nwr_q;

    // Pointers wrap naturally at 2^ADDR_W.
    always_comb begin
        src_d   = src_q + ADDR_W'(1);
        dst_d   = dst_q + ADDR_W'(1);
        bytes_d = bytes_q + LEN_W'(1);
    end

    // Memory strobes are registered alongside the state they belong to, so they are
    // loaded on the edge that enters RD/WR rather than decoded from the current state.
    always_ff @(posedge clk or negedge rst_out) begin
        if (!rst_out) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            bytes_q   <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            ce_q      <= 1'b0;
            nwr_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    ce_q   <= 1'b0;
                    nwr_q  <= 1'b0;
                    if (start) begin
                        src_q     <= src_addr;
                        dst_q     <= dst_addr;
                        len_q     <= length;
                        bytes_q   <= '0;
                        aborted_q <= 1'b0;
                        if (length != '0) begin
                            state_q <= RD;
                            busy_q  <= 1'b1;
                            ce_q    <= 1'b1;
                            addr_q  <= src_addr;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    ce_q <= 1'b0;
                    if (abort) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else begin
                        state_q <= LAT;
                    end
                end
                LAT: begin
                    wdata_q <= mem_rdata;
                    if (abort) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else begin
                        state_q <= WR;
                        ce_q    <= 1'b1;
                        nwr_q   <= 1'b1;
                        addr_q  <= dst_q;
                    end
                end
                WR: begin
                    bytes_q <= bytes_d;
                    src_q   <= src_d;
                    dst_q   <= dst_d;
                    nwr_q   <= 1'b0;
                    // The in-flight write always lands; abort only decides how we finish.
                    if (abort || bytes_d == len_q) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        aborted_q <= abort;
                        ce_q      <= 1'b0;
                    end else begin
                        state_q <= RD;
                        ce_q    <= 1'b1;
                        addr_q  <= src_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign bytes_done = bytes_q;
    assign mem_ce     = ce_q;
    assign mem_nw_r   = nwr_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: behavioural memory, a reference copy model built from the
// byte-timing rules, and scenario tasks for normal, wrap, abort, reset and random copies.
module tb_dma_copy_engine;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int LW    = 11;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_out = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy, done, aborted, mem_ce, mem_nw_r;
    logic [LW-1:0] bytes_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    int errors = 0;
    int checks = 0;

    dma_copy_engine #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst_out(rst_out), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .aborted(aborted), .bytes_done(bytes_done),
        .mem_ce(mem_ce), .mem_nw_r(mem_nw_r), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory with registered read data, plus a bench-side preload port.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_ce && mem_nw_r) mem[mem_addr] <= mem_wdata;
        if (mem_ce && !mem_nw_r) mem_rdata <= mem[mem_addr];
    end

    task automatic poke(input int a, input int d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = AW'(a);
        pre_data = DW'(d);
        ref_mem[a % DEPTH] = DW'(d);
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            pre_we   = 1'b1;
            pre_addr = AW'(i);
            pre_data = DW'($urandom);
            ref_mem[i] = pre_data;
        end
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // One transfer; abort_cyc = 0 means no abort, spurious pulses start in cycle 2.
    task automatic run_xfer(input string name, input int s, input int d, input int n,
                            input int abort_cyc, input bit spurious);
        int exp_written, exp_done, exp_ab, k, ph;
        int done_cyc, done_cnt, busy_cnt, ce_bad, diffs;
        if (abort_cyc > 0 && abort_cyc <= 3 * n) begin
            k  = (abort_cyc - 1) / 3;
            ph = (abort_cyc - 1) % 3;
            exp_written = (ph == 2) ? k + 1 : k;
            exp_done    = abort_cyc + 1;
            exp_ab      = 1;
        end else begin
            exp_written = n;
            exp_done    = 3 * n + 1;
            exp_ab      = 0;
        end
        for (int i = 0; i < exp_written; i++)
            ref_mem[(d + i) % DEPTH] = ref_mem[(s + i) % DEPTH];

        done_cyc = 0; done_cnt = 0; busy_cnt = 0; ce_bad = 0;
        @(negedge clk);
        start    = 1'b1;
        src_addr = AW'(s);
        dst_addr = AW'(d);
        length   = LW'(n);
        @(posedge clk);
        for (int c = 1; c <= exp_done + 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (c == abort_cyc);
            if (spurious && c == 2) begin
                start    = 1'b1;
                src_addr = AW'($urandom);
                dst_addr = AW'($urandom);
                length   = LW'($urandom_range(1, 20));
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (busy) busy_cnt++;
            if (mem_ce && !busy) ce_bad++;
        end
        abort = 1'b0;
        start = 1'b0;

        checks++;
        if (done_cyc !== exp_done) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
        end
        checks++;
        if (busy_cnt !== exp_done - 1) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_done - 1);
        end
        checks++;
        if (bytes_done !== LW'(exp_written)) begin
            errors++;
            $display("FAIL %s bytes_done: got %0d expected %0d", name, bytes_done, exp_written);
        end
        checks++;
        if (aborted !== exp_ab[0]) begin
            errors++;
            $display("FAIL %s aborted: got %0b expected %0b", name, aborted, exp_ab[0]);
        end
        checks++;
        if (ce_bad !== 0) begin
            errors++;
            $display("FAIL %s ce_while_not_busy: got %0d expected 0", name, ce_bad);
        end
        diffs = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== ref_mem[i]) diffs++;
        checks++;
        if (diffs !== 0) begin
            errors++;
            $display("FAIL %s memory: %0d differing bytes, expected 0", name, diffs);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({busy, done, aborted, bytes_done, mem_ce, mem_nw_r, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL %s outputs: busy=%0b done=%0b ab=%0b bd=%0d ce=%0b nwr=%0b addr=%h wd=%h expected all 0",
                     name, busy, done, aborted, bytes_done, mem_ce, mem_nw_r, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_reset();
        rst_out = 1'b0;
        #1;
        check_outputs_zero("reset");
        fill_random();
        @(negedge clk);
        check_outputs_zero("reset_hold");
        rst_out = 1'b1;
    endtask

    task automatic test_basic();
        poke(0, 8'h3A); poke(1, 8'h7F); poke(2, 8'hC2); poke(3, 8'h1D);
        run_xfer("basic", 'h000, 'h100, 4, 0, 1'b0);
        checks++;
        if ({mem[256], mem[257], mem[258], mem[259]} !== 32'h3A7FC21D) begin
            errors++;
            $display("FAIL basic_bytes: got %h%h%h%h expected 3a7fc21d", mem[256], mem[257], mem[258], mem[259]);
        end
    endtask

    task automatic test_len0();
        run_xfer("len0", 'h055, 'h0AA, 0, 0, 1'b0);
    endtask

    task automatic test_wrap();
        poke('h3FE, 8'hA9); poke('h3FF, 8'h4E); poke('h000, 8'h95); poke('h001, 8'h6B);
        run_xfer("wrap", 'h3FE, 'h200, 4, 0, 1'b0);
        checks++;
        if ({mem[512], mem[513], mem[514], mem[515]} !== 32'hA94E956B) begin
            errors++;
            $display("FAIL wrap_bytes: got %h%h%h%h expected a94e956b", mem[512], mem[513], mem[514], mem[515]);
        end
    endtask

    task automatic test_abort();
        run_xfer("abort_lat", 'h040, 'h300, 8, 8, 1'b0);
        run_xfer("abort_rd", 'h050, 'h310, 5, 4, 1'b0);
        run_xfer("abort_wr_last", 'h060, 'h320, 3, 9, 1'b0);
    endtask

    task automatic test_ignored_start();
        run_xfer("ignored_start", 'h070, 'h330, 6, 0, 1'b1);
    endtask

    task automatic test_overlap();
        run_xfer("overlap", 'h010, 'h012, 6, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int diffs;
        for (int i = 0; i < 3; i++) ref_mem[('h380 + i) % DEPTH] = ref_mem[('h080 + i) % DEPTH];
        @(negedge clk);
        start = 1'b1; src_addr = AW'('h080); dst_addr = AW'('h380); length = LW'(6);
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_out = 1'b0;
        #1;
        check_outputs_zero("reset_mid");
        repeat (2) @(negedge clk);
        rst_out = 1'b1;
        diffs = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== ref_mem[i]) diffs++;
        checks++;
        if (diffs !== 0) begin
            errors++;
            $display("FAIL reset_mid_memory: %0d differing bytes, expected 0", diffs);
        end
        run_xfer("after_reset", 'h090, 'h390, 5, 0, 1'b0);
    endtask

    task automatic test_random();
        int n, ac;
        for (int t = 0; t < 10; t++) begin
            n  = $urandom_range(1, 12);
            ac = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3 * n) : 0;
            run_xfer($sformatf("random%0d", t), $urandom_range(0, DEPTH - 1),
                     $urandom_range(0, DEPTH - 1), n, ac, $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic test_full_length();
        run_xfer("full_length", 'h000, 'h200, DEPTH, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_wrap();
        test_abort();
        test_ignored_start();
        test_overlap();
        test_reset_mid();
        test_random();
        test_full_length();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
